// File: rtl/instr_sequencer.sv
// Fetch/execute/memory sequencer for the 9-bit-instruction core.
// Owns the PC, gates register-file writes and stalls on data memory through req/ack.
//
// state | meaning
// IDLE  | waiting for start after reset
// FETCH | instruction register captures the word at pc
// EXEC  | decoder flags evaluated, next pc chosen
// MEM   | data memory request outstanding, waiting for ack or timeout
// HALT  | stopped on halt instruction (done) or memory timeout (error)
module instr_sequencer #(
  parameter int PC_W  = 10,
  parameter int OFF_W = 6,
  parameter int TMO   = 15,
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic [PC_W-1:0]  start_addr_i,
  input  logic             branch_i,
  input  logic             jump_i,
  input  logic             mem_read_i,
  input  logic             mem_write_i,
  input  logic             halt_instr_i,
  input  logic             zero_i,
  input  logic [PC_W-1:0]  target_i,
  input  logic [OFF_W-1:0] offset_i,
  input  logic             mem_ack_i,
  output logic [PC_W-1:0]  pc_o,
  output logic             ir_load_o,
  output logic             reg_we_en_o,
  output logic             mem_req_o,
  output logic             done_o,
  output logic             error_o,
  output logic [CNT_W-1:0] cycle_cnt_o
);

  typedef enum logic [2:0] {IDLE, FETCH, EXEC, MEM, HALT} state_e;

  state_e           state_q;
  logic [PC_W-1:0]  pc_q;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       tmo_q;
  logic             done_q;
  logic             error_q;

  logic [PC_W-1:0]  off_sext;
  logic             is_mem;

  assign off_sext = {{(PC_W-OFF_W){offset_i[OFF_W-1]}}, offset_i};
  assign is_mem   = mem_read_i | mem_write_i;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      if ((state_q == FETCH || state_q == EXEC || state_q == MEM) && cnt_q != '1)
        cnt_q <= cnt_q + 1'b1;
      case (state_q)
        IDLE, HALT: begin
          if (start_i) begin
            pc_q    <= start_addr_i;
            cnt_q   <= '0;
            tmo_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        FETCH: state_q <= EXEC;
        EXEC: begin
          if (halt_instr_i) begin
            done_q  <= 1'b1;
            state_q <= HALT;
          end else if (is_mem) begin
            tmo_q   <= '0;
            state_q <= MEM;
          end else begin
            // jump outranks a taken branch
            if (jump_i)                 pc_q <= target_i;
            else if (branch_i && zero_i) pc_q <= pc_q + off_sext;
            else                         pc_q <= pc_q + 1'b1;
            state_q <= FETCH;
          end
        end
        MEM: begin
          if (mem_ack_i) begin
            pc_q    <= pc_q + 1'b1;
            tmo_q   <= '0;
            state_q <= FETCH;
          end else if (tmo_q == 8'(TMO - 1)) begin
            tmo_q   <= '0;
            error_q <= 1'b1;
            state_q <= HALT;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Write enable must coincide with the EXEC / ack cycle, so it is decoded rather than registered.
  assign reg_we_en_o = (state_q == EXEC && !halt_instr_i && !is_mem) ||
                       (state_q == MEM && mem_ack_i);
  assign ir_load_o   = (state_q == FETCH);
  assign mem_req_o   = (state_q == MEM);
  assign pc_o        = pc_q;
  assign done_o      = done_q;
  assign error_o     = error_q;
  assign cycle_cnt_o = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: the driver pushes expected fetch/writeback/halt
// events, a negedge monitor pops and compares them as the DUT presents them.
module tb_instr_sequencer;

  localparam int TMO = 15;
  localparam int EV_FETCH = 0, EV_WB = 1, EV_HALT = 2;

  logic        clk = 1'b0;
  logic        reset, start, branch, jump, mem_read, mem_write, halt_instr, zero, mem_ack;
  logic [9:0]  start_addr, target, pc;
  logic [5:0]  offset;
  logic        ir_load, reg_we_en, mem_req, done, error;
  logic [15:0] cycle_cnt;

  typedef struct {int kind; int a; int b;} ev_t;
  ev_t sb[$];

  int errors = 0;
  int checks = 0;
  int exp_pc = 0;
  int exp_cc = 0;
  logic prev_de = 1'b0;

  instr_sequencer dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .start_addr_i(start_addr),
    .branch_i(branch), .jump_i(jump), .mem_read_i(mem_read), .mem_write_i(mem_write),
    .halt_instr_i(halt_instr), .zero_i(zero), .target_i(target), .offset_i(offset),
    .mem_ack_i(mem_ack), .pc_o(pc), .ir_load_o(ir_load), .reg_we_en_o(reg_we_en),
    .mem_req_o(mem_req), .done_o(done), .error_o(error), .cycle_cnt_o(cycle_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input int k, input int a, input int b);
    ev_t e;
    e.kind = k; e.a = a; e.b = b;
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input string name, input int k, input logic [31:0] a, input logic [31:0] b);
    ev_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s: unexpected event got a=%0d b=%0d expected nothing", name, a, b);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || a !== 32'(e.a) || b !== 32'(e.b)) begin
        errors++;
        $display("FAIL %s: got kind=%0d a=%0d b=%0d expected kind=%0d a=%0d b=%0d",
                 name, k, a, b, e.kind, e.a, e.b);
      end
    end
  endtask

  // Monitor
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (ir_load)                     pop_cmp("fetch", EV_FETCH, 32'(pc), 32'(cycle_cnt));
        if (reg_we_en)                   pop_cmp("writeback", EV_WB, 32'(pc), 32'd0);
        if ((done | error) && !prev_de)  pop_cmp("halt", EV_HALT, 32'(done), 32'(error));
      end
      prev_de = done | error;
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_fetch;
    int n = 0;
    while (ir_load !== 1'b1 && n < 50) begin
      tick();
      n++;
    end
    if (ir_load !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL fetch_timeout: got ir_load=%0b expected 1 within 50 cycles", ir_load);
    end
  endtask

  task automatic do_start(input int addr);
    start = 1'b1;
    start_addr = 10'(addr);
    tick();
    start = 1'b0;
    exp_pc = addr;
    exp_cc = 0;
  endtask

  // n_mem: MEM cycles up to and including the ack cycle; 0 means never ack
  task automatic run_instr(input logic br, input logic jp, input logic mr, input logic mw,
                           input logic hl, input logic z, input int tgt, input int off,
                           input int n_mem, input logic pulse_start);
    int cnt;
    push(EV_FETCH, exp_pc, exp_cc);
    wait_fetch();
    branch = br; jump = jp; mem_read = mr; mem_write = mw; halt_instr = hl; zero = z;
    target = 10'(tgt); offset = 6'(off);
    if (hl) begin
      push(EV_HALT, 1, 0);
    end else if (mr | mw) begin
      if (n_mem > 0) begin
        push(EV_WB, exp_pc, 0);
        exp_pc = (exp_pc + 1) & 1023;
        exp_cc += 2 + n_mem;
      end else begin
        push(EV_HALT, 0, 1);
      end
    end else begin
      push(EV_WB, exp_pc, 0);
      if (jp)            exp_pc = tgt;
      else if (br && z)  exp_pc = (exp_pc + off) & 1023;
      else               exp_pc = (exp_pc + 1) & 1023;
      exp_cc += 2;
    end
    tick();
    if (pulse_start) begin
      start = 1'b1;
      start_addr = 10'd999;
    end
    tick();
    start = 1'b0;
    branch = 0; jump = 0; mem_read = 0; mem_write = 0; halt_instr = 0; zero = 0;
    if (mr | mw) begin
      cnt = 0;
      while (mem_req === 1'b1 && cnt < 40) begin
        cnt++;
        if (cnt == n_mem) mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
      end
      check("mem_req_cycles", 32'(cnt), 32'(n_mem > 0 ? n_mem : TMO));
      check("mem_req_drop", 32'(mem_req), 32'd0);
      if (n_mem == 0) check("timeout_error", 32'(error), 32'd1);
    end
  endtask

  initial begin
    reset = 1; start = 0; branch = 0; jump = 0; mem_read = 0; mem_write = 0;
    halt_instr = 0; zero = 0; mem_ack = 0; start_addr = '0; target = '0; offset = '0;
    repeat (3) tick();
    check("rst_pc", 32'(pc), 32'd0);
    check("rst_ir_load", 32'(ir_load), 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_done_error", 32'({done, error}), 32'd0);
    check("rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    reset = 0;
    repeat (3) tick();
    check("idle_without_start", 32'(ir_load), 32'd0);

    do_start(5);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);      // start in EXEC ignored
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    run_instr(0, 1, 0, 0, 0, 0, 20, 0, 0, 0);     // 8 -> 20
    run_instr(1, 0, 0, 0, 0, 1, 0, -4, 0, 0);     // 20 -> 16
    run_instr(0, 1, 0, 0, 0, 0, 20, 0, 0, 0);     // 16 -> 20
    run_instr(1, 0, 0, 0, 0, 0, 0, -4, 0, 0);     // not taken -> 21
    run_instr(1, 1, 0, 0, 0, 1, 100, 5, 0, 0);    // jump wins -> 100
    run_instr(0, 1, 0, 0, 0, 0, 1023, 0, 0, 0);   // -> 1023
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);      // wrap -> 0
    run_instr(1, 0, 0, 0, 0, 1, 0, -4, 0, 0);     // 0 - 4 -> 1020
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 3, 0);      // load, ack in 3rd MEM cycle
    run_instr(0, 0, 0, 1, 0, 0, 0, 0, 1, 0);      // store, immediate ack
    run_instr(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);      // load, never acked

    repeat (3) tick();
    check("tmo_error_held", 32'(error), 32'd1);
    check("tmo_done_low", 32'(done), 32'd0);
    check("tmo_pc_held", 32'(pc), 32'd1022);
    check("tmo_stays_halted", 32'(ir_load), 32'd0);

    do_start(50);
    check("restart_error_clr", 32'(error), 32'd0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);      // 50 -> 51, start ignored
    run_instr(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);      // halt at 51
    repeat (3) tick();
    check("halt_done_held", 32'(done), 32'd1);
    check("halt_pc_held", 32'(pc), 32'd51);
    check("halt_no_fetch", 32'(ir_load), 32'd0);
    do_start(7);
    check("restart_done_clr", 32'(done), 32'd0);
    check("restart_cycle_cnt", 32'(cycle_cnt), 32'd0);

    push(EV_FETCH, 7, 0);
    wait_fetch();
    mem_read = 1'b1;
    tick();
    tick();
    mem_read = 1'b0;
    check("pre_reset_mem_req", 32'(mem_req), 32'd1);
    reset = 1'b1;
    tick();
    check("mid_rst_pc", 32'(pc), 32'd0);
    check("mid_rst_mem_req", 32'(mem_req), 32'd0);
    check("mid_rst_outputs", 32'({ir_load, reg_we_en, done, error}), 32'd0);
    check("mid_rst_cycle_cnt", 32'(cycle_cnt), 32'd0);
    reset = 1'b0;
    repeat (3) tick();
    check("post_rst_idle", 32'(ir_load), 32'd0);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
